// File: rtl/bp_cce_dir_lookup_seq.sv
// bp_cce_dir_lookup_seq
//   Sequences a directory way-group lookup for the CCE. A lookup (way-group,
//   tag) is accepted in IDLE, the directory RAM is then read one row per
//   cycle, and every entry of every LCE is tag-compared. The per-LCE hit, way
//   and coherence-state results are consolidated into vectors that are held
//   in DONE until the consumer acknowledges them with sharers_yumi_i.
//
//   Ports
//     clk_i, reset_i          clock, synchronous active-low reset
//     lkup_v_i/lkup_ready_o   lookup handshake (wg, tag)
//     ram_v_o/ram_addr_o      directory RAM read, address {wg, row}
//     ram_data_i              row data, valid the cycle after ram_v_o
//     sharers_*_o             consolidated result, valid with sharers_v_o
//     sharers_yumi_i          consumer takes the result
//     multihit_o              sticky multi-hit error flag
//
//   Handshakes: a lookup transfers on a cycle where lkup_v_i & lkup_ready_o;
//   the result transfers on a cycle where sharers_v_o & sharers_yumi_i. The
//   requester holds lkup_v_i until it transfers; valid/yumi outside those
//   states are ignored.
//
//   Optional feature: define BP_CCE_DIR_MULTIHIT_CHECK_EN to build the
//   multi-hit checker; otherwise multihit_o is tied to 0.

`ifndef BP_COH_BITS
`define BP_COH_BITS 3
`endif

module bp_cce_dir_lookup_seq #(
  parameter int num_lce_p     = 8,
  parameter int lce_assoc_p   = 8,
  parameter int lce_per_row_p = 2,
  parameter int tag_width_p   = 28,
  parameter int wg_width_p    = 6,
  localparam int rows_lp      = num_lce_p / lce_per_row_p,
  localparam int lg_rows_lp   = (rows_lp > 1) ? $clog2(rows_lp) : 1,
  localparam int lg_assoc_lp  = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int coh_bits_lp  = `BP_COH_BITS,
  localparam int entry_lp     = tag_width_p + coh_bits_lp,
  localparam int row_width_lp = lce_per_row_p * lce_assoc_p * entry_lp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 lkup_v_i,
  output logic                                 lkup_ready_o,
  input  logic [wg_width_p-1:0]                lkup_wg_i,
  input  logic [tag_width_p-1:0]               lkup_tag_i,
  output logic                                 ram_v_o,
  output logic [wg_width_p+lg_rows_lp-1:0]     ram_addr_o,
  input  logic [row_width_lp-1:0]              ram_data_i,
  output logic                                 sharers_v_o,
  output logic [num_lce_p-1:0]                 sharers_hits_o,
  output logic [num_lce_p*lg_assoc_lp-1:0]     sharers_ways_o,
  output logic [num_lce_p*coh_bits_lp-1:0]     sharers_coh_states_o,
  input  logic                                 sharers_yumi_i,
  output logic                                 multihit_o
);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_read = 2'd1,
    e_last = 2'd2,
    e_done = 2'd3
  } state_e;

  localparam logic [coh_bits_lp-1:0] coh_i_lp = '0;
  localparam logic [lg_rows_lp-1:0]  last_row_lp = lg_rows_lp'(rows_lp - 1);

  state_e                           state_q, state_d;
  logic [lg_rows_lp-1:0]            row_q, row_d;
  logic [wg_width_p-1:0]            wg_q, wg_d;
  logic [tag_width_p-1:0]           tag_q, tag_d;
  logic [num_lce_p-1:0]             hits_q, hits_d;
  logic [num_lce_p*lg_assoc_lp-1:0] ways_q, ways_d;
  logic [num_lce_p*coh_bits_lp-1:0] states_q, states_d;

  // Row currently being consumed from ram_data_i (one cycle behind row_q).
  logic                  proc_v;
  logic [lg_rows_lp-1:0] proc_row;

  // Per-LCE compare results for the row on ram_data_i.
  logic [lce_per_row_p-1:0]                  row_hit;
  logic [lce_per_row_p-1:0][lg_assoc_lp-1:0] row_way;
  logic [lce_per_row_p-1:0][coh_bits_lp-1:0] row_state;
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
  logic                                      row_multi;
`endif

  // Tag compare: ascending scan so the first (lowest) hitting way wins.
  always_comb begin
    logic [entry_lp-1:0] ent;
    row_hit   = '0;
    row_way   = '0;
    row_state = '0;
    ent       = '0;
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
    row_multi = 1'b0;
`endif
    for (int l = 0; l < lce_per_row_p; l++) begin
      for (int e = 0; e < lce_assoc_p; e++) begin
        ent = ram_data_i[(l*lce_assoc_p+e)*entry_lp +: entry_lp];
        if ((ent[entry_lp-1 -: tag_width_p] == tag_q) &&
            (ent[coh_bits_lp-1:0] != coh_i_lp)) begin
          if (!row_hit[l]) begin
            row_way[l]   = lg_assoc_lp'(e);
            row_state[l] = ent[coh_bits_lp-1:0];
          end
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
          else begin
            row_multi = 1'b1;
          end
`endif
          row_hit[l] = 1'b1;
        end
      end
    end
  end

  // Next-state and accumulator update.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    wg_d     = wg_q;
    tag_d    = tag_q;
    hits_d   = hits_q;
    ways_d   = ways_q;
    states_d = states_q;
    proc_v   = 1'b0;
    proc_row = '0;

    unique case (state_q)
      e_idle: begin
        if (lkup_v_i) begin
          wg_d     = lkup_wg_i;
          tag_d    = lkup_tag_i;
          hits_d   = '0;
          ways_d   = '0;
          states_d = '0;
          row_d    = '0;
          state_d  = e_read;
        end
      end
      e_read: begin
        // Data for row r-1 arrives while row r is being addressed.
        proc_v   = (row_q != '0);
        proc_row = row_q - 1'b1;
        if (row_q == last_row_lp) begin
          state_d = e_last;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      e_last: begin
        proc_v   = 1'b1;
        proc_row = row_q;
        state_d  = e_done;
      end
      e_done: begin
        if (sharers_yumi_i) begin
          row_d   = '0;
          state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase

    for (int g = 0; g < num_lce_p; g++) begin
      if (proc_v && (proc_row == lg_rows_lp'(g / lce_per_row_p))) begin
        hits_d[g]                             = row_hit[g % lce_per_row_p];
        ways_d[g*lg_assoc_lp +: lg_assoc_lp]  = row_way[g % lce_per_row_p];
        states_d[g*coh_bits_lp +: coh_bits_lp] = row_state[g % lce_per_row_p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= e_idle;
      row_q    <= '0;
      wg_q     <= '0;
      tag_q    <= '0;
      hits_q   <= '0;
      ways_q   <= '0;
      states_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      wg_q     <= wg_d;
      tag_q    <= tag_d;
      hits_q   <= hits_d;
      ways_q   <= ways_d;
      states_q <= states_d;
    end
  end

`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
  logic multihit_q;
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      multihit_q <= 1'b0;
    end else if (proc_v && row_multi) begin
      multihit_q <= 1'b1;
    end
  end
  assign multihit_o = reset_i & multihit_q;
`else
  assign multihit_o = 1'b0;
`endif

  // Control outputs are forced low while reset is asserted.
  assign lkup_ready_o         = reset_i & (state_q == e_idle);
  assign ram_v_o              = reset_i & (state_q == e_read);
  assign ram_addr_o           = {wg_q, row_q};
  assign sharers_v_o          = reset_i & (state_q == e_done);
  assign sharers_hits_o       = hits_q;
  assign sharers_ways_o       = ways_q;
  assign sharers_coh_states_o = states_q;

endmodule

// File: tb/tb_bp_cce_dir_lookup_seq.sv
module tb_bp_cce_dir_lookup_seq;

  localparam int NL   = 4;
  localparam int NA   = 2;
  localparam int LPR  = 2;
  localparam int TW   = 28;
  localparam int WGW  = 6;
  localparam int CB   = 3;
  localparam int ROWS = NL / LPR;
  localparam int LGR  = 1;
  localparam int LGA  = 1;
  localparam int EW   = TW + CB;
  localparam int RW   = LPR * NA * EW;
  localparam int AW   = WGW + LGR;

  localparam logic [CB-1:0] COH_I = 3'd0;
  localparam logic [CB-1:0] COH_S = 3'd1;
  localparam logic [CB-1:0] COH_E = 3'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic              lkup_v_i = 1'b0;
  logic              lkup_ready_o;
  logic [WGW-1:0]    lkup_wg_i = '0;
  logic [TW-1:0]     lkup_tag_i = '0;
  logic              ram_v_o;
  logic [AW-1:0]     ram_addr_o;
  logic [RW-1:0]     ram_data_i = '0;
  logic              sharers_v_o;
  logic [NL-1:0]     sharers_hits_o;
  logic [NL*LGA-1:0] sharers_ways_o;
  logic [NL*CB-1:0]  sharers_coh_states_o;
  logic              sharers_yumi_i = 1'b0;
  logic              multihit_o;

  bp_cce_dir_lookup_seq #(
    .num_lce_p(NL), .lce_assoc_p(NA), .lce_per_row_p(LPR),
    .tag_width_p(TW), .wg_width_p(WGW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .lkup_v_i(lkup_v_i), .lkup_ready_o(lkup_ready_o),
    .lkup_wg_i(lkup_wg_i), .lkup_tag_i(lkup_tag_i),
    .ram_v_o(ram_v_o), .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i),
    .sharers_v_o(sharers_v_o), .sharers_hits_o(sharers_hits_o),
    .sharers_ways_o(sharers_ways_o),
    .sharers_coh_states_o(sharers_coh_states_o),
    .sharers_yumi_i(sharers_yumi_i), .multihit_o(multihit_o)
  );

  // directory memory model, indexed by wg*ROWS + row
  logic [RW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // RAM responder: data for a read appears one cycle after ram_v_o,
  // garbage otherwise.
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  always @(negedge clk) begin
    if (pend_v) ram_data_i = mem[pend_addr];
    else        ram_data_i = rand_row();
    pend_v    = ram_v_o;
    pend_addr = ram_addr_o;
  end

  // scoreboard
  int n_checks = 0;
  int n_errs   = 0;
  logic exp_mh = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per LCE, first valid matching way wins; more than one
  // matching way flags a multi-hit.
  task automatic model(input logic [WGW-1:0] wg, input logic [TW-1:0] tag,
                       output logic [NL-1:0] hits, output logic [NL*LGA-1:0] ways,
                       output logic [NL*CB-1:0] sts, output logic mh);
    logic [RW-1:0] rd;
    logic [EW-1:0] ent;
    int nhit;
    hits = '0; ways = '0; sts = '0; mh = 1'b0;
    for (int g = 0; g < NL; g++) begin
      rd = mem[int'(wg) * ROWS + g / LPR];
      nhit = 0;
      for (int e = 0; e < NA; e++) begin
        ent = rd[((g % LPR) * NA + e) * EW +: EW];
        if (ent[EW-1 -: TW] == tag && ent[CB-1:0] != COH_I) begin
          if (nhit == 0) begin
            hits[g] = 1'b1;
            ways[g*LGA +: LGA] = LGA'(e);
            sts[g*CB +: CB] = ent[CB-1:0];
          end
          nhit++;
        end
      end
      if (nhit > 1) mh = 1'b1;
    end
  endtask

  task automatic set_entry(input logic [WGW-1:0] wg, input int lce, input int way,
                           input logic [TW-1:0] tag, input logic [CB-1:0] coh);
    mem[int'(wg) * ROWS + lce / LPR][((lce % LPR) * NA + way) * EW +: EW] = {tag, coh};
  endtask

  // fill a way-group with entries whose tags never match 'tag'
  task automatic fill_bg(input logic [WGW-1:0] wg, input logic [TW-1:0] tag);
    logic [TW-1:0] t;
    for (int g = 0; g < NL; g++)
      for (int e = 0; e < NA; e++) begin
        t = TW'($urandom);
        if (t == tag) t = ~t;
        set_entry(wg, g, e, t, CB'($urandom_range(0, 7)));
      end
  endtask

  // driver: full lookup with cycle-accurate checks; starts and ends just
  // after a negedge with the DUT in IDLE
  task automatic run_lookup(input logic [WGW-1:0] wg, input logic [TW-1:0] tag, input int hold);
    logic [NL-1:0] eh; logic [NL*LGA-1:0] ew; logic [NL*CB-1:0] es; logic mh;
    check("ready_idle", lkup_ready_o, 1'b1);
    lkup_v_i = 1'b1; lkup_wg_i = wg; lkup_tag_i = tag;
    @(negedge clk);  // cycle 1: READ row 0
    lkup_wg_i = WGW'($urandom); lkup_tag_i = TW'($urandom);
    check("c1_ram_v", ram_v_o, 1'b1);
    check("c1_addr", ram_addr_o, {wg, 1'b0});
    check("c1_ready", lkup_ready_o, 1'b0);
    sharers_yumi_i = 1'($urandom_range(0, 1));
    @(negedge clk);  // cycle 2: READ row 1
    check("c2_ram_v", ram_v_o, 1'b1);
    check("c2_addr", ram_addr_o, {wg, 1'b1});
    sharers_yumi_i = 1'($urandom_range(0, 1));
    @(negedge clk);  // cycle 3: LAST
    check("c3_ram_v", ram_v_o, 1'b0);
    check("c3_sv", sharers_v_o, 1'b0);
    sharers_yumi_i = 1'($urandom_range(0, 1));
    @(negedge clk);  // cycle 4: DONE
    model(wg, tag, eh, ew, es, mh);
`ifdef BP_CCE_DIR_MULTIHIT_CHECK_EN
    exp_mh = exp_mh | mh;
`endif
    sharers_yumi_i = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check("done_sv", sharers_v_o, 1'b1);
      check("done_ready", lkup_ready_o, 1'b0);
      check("hits", sharers_hits_o, eh);
      check("ways", sharers_ways_o, ew);
      check("states", sharers_coh_states_o, es);
      check("multihit", multihit_o, exp_mh);
    end
    sharers_yumi_i = 1'b1; lkup_v_i = 1'b0;
    @(negedge clk);
    sharers_yumi_i = 1'b0;
    check("post_sv", sharers_v_o, 1'b0);
    check("post_ready", lkup_ready_o, 1'b1);
    check("post_ram_v", ram_v_o, 1'b0);
    check("post_multihit", multihit_o, exp_mh);
  endtask

  initial begin
    logic [WGW-1:0] wg;
    logic [TW-1:0]  tag;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // reset held for 3 cycles
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", lkup_ready_o, 1'b0);
      check("rst_sv", sharers_v_o, 1'b0);
      check("rst_ram_v", ram_v_o, 1'b0);
      check("rst_multihit", multihit_o, 1'b0);
    end
    reset_i = 1'b1;
    @(negedge clk);
    check("rel_ready", lkup_ready_o, 1'b1);

    // single hit: LCE2 way1 in E, held 5 cycles
    fill_bg(6'd5, 28'h123);
    set_entry(6'd5, 2, 1, 28'h123, COH_E);
    run_lookup(6'd5, 28'h123, 5);
    check("single_hits", sharers_hits_o, 4'b0100);

    // matching tag in state I is not a hit; LCE3 way0 in S is
    fill_bg(6'd9, 28'hABCDE);
    set_entry(6'd9, 0, 0, 28'hABCDE, COH_I);
    set_entry(6'd9, 3, 0, 28'hABCDE, COH_S);
    run_lookup(6'd9, 28'hABCDE, 0);

    // multi-hit: LCE1 both ways in S
    fill_bg(6'd17, 28'h5555);
    set_entry(6'd17, 1, 0, 28'h5555, COH_S);
    set_entry(6'd17, 1, 1, 28'h5555, COH_S);
    run_lookup(6'd17, 28'h5555, 2);

    // mid-lookup reset in READ at row 1
    fill_bg(6'd33, 28'h777);
    set_entry(6'd33, 0, 0, 28'h777, COH_E);
    check("mr_ready", lkup_ready_o, 1'b1);
    lkup_v_i = 1'b1; lkup_wg_i = 6'd33; lkup_tag_i = 28'h777;
    @(negedge clk);
    lkup_v_i = 1'b0;
    @(negedge clk);
    check("mr_addr", ram_addr_o, {6'd33, 1'b1});
    reset_i = 1'b0;
    @(negedge clk);
    check("mr_rst_ready", lkup_ready_o, 1'b0);
    check("mr_rst_ram_v", ram_v_o, 1'b0);
    check("mr_rst_sv", sharers_v_o, 1'b0);
    reset_i = 1'b1;
    exp_mh = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mr_idle_ready", lkup_ready_o, 1'b1);
      check("mr_idle_sv", sharers_v_o, 1'b0);
      check("mr_idle_ram_v", ram_v_o, 1'b0);
      check("mr_multihit", multihit_o, 1'b0);
    end

    // randomized lookups
    for (int n = 0; n < 40; n++) begin
      wg  = WGW'($urandom_range(0, (1 << WGW) - 1));
      tag = TW'($urandom);
      for (int g = 0; g < NL; g++)
        for (int e = 0; e < NA; e++)
          set_entry(wg, g, e, ($urandom_range(0, 2) == 0) ? tag : TW'($urandom),
                    CB'($urandom_range(0, 3)));
      run_lookup(wg, tag, $urandom_range(0, 3));
      for (int i = $urandom_range(0, 2); i > 0; i--) begin
        @(negedge clk);
        check("gap_ready", lkup_ready_o, 1'b1);
        check("gap_sv", sharers_v_o, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_cce_dir_lookup_seq.md
Name: bp_cce_dir_lookup_seq

Overview:
- Sequences directory way-group reads for the CCE.
- Accepts a lookup for a way-group and tag, then reads the directory RAM one row per cycle.
- Tag-compares every entry and consolidates the results into per-LCE hit, way and coherence-state vectors.
- The vectors feed the auxiliary-directory flag logic. Results are held until the consumer acknowledges them.

Parameters:
- num_lce_p, 8, number of LCEs tracked by the directory
- lce_assoc_p, 8, ways per LCE set
- lce_per_row_p, 2, LCEs stored per directory RAM row; must divide num_lce_p
- tag_width_p, 28, stored tag width
- wg_width_p, 6, way-group index width
- Derived:
  - rows_lp = num_lce_p/lce_per_row_p
  - lg_rows_lp = BSG_SAFE_CLOG2(rows_lp)
  - entry_lp = tag_width_p + `bp_coh_bits (tag in the MSBs)
  - row_width_lp = lce_per_row_p*lce_assoc_p*entry_lp

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-low reset
- lkup_v_i  in  1  lookup request valid
- lkup_ready_o  out  1  block can accept a lookup
- lkup_wg_i  in  wg_width_p  way-group index
- lkup_tag_i  in  tag_width_p  tag to compare
- ram_v_o  out  1  directory RAM read enable
- ram_addr_o  out  wg_width_p+lg_rows_lp  address {wg, row}
- ram_data_i  in  row_width_lp  row data, valid the cycle after ram_v_o
  - entry e of LCE l in the row sits at index (l*lce_assoc_p+e)
- sharers_v_o  out  1  consolidated result valid
- sharers_hits_o  out  num_lce_p  per-LCE hit
- sharers_ways_o  out  num_lce_p*lg(lce_assoc_p)  way of the hit per LCE
- sharers_coh_states_o  out  num_lce_p*`bp_coh_bits  state of the hit per LCE
- sharers_yumi_i  in  1  consumer takes result; legal only while sharers_v_o
- multihit_o  out  1  sticky multi-hit error (see Optional Feature)

Behaviour:
- States: IDLE, READ, LAST, DONE.
- Reset (reset_i==0 at posedge), from any state including mid-lookup:
  - go to IDLE; row counter = 0; result registers cleared
  - sharers_v_o = 0, ram_v_o = 0, multihit_o = 0, lkup_ready_o = 0 during reset
- lkup_ready_o = 1 only in IDLE, out of reset.
- IDLE:
  - on lkup_v_i & lkup_ready_o, register wg and tag, clear the hits/ways/states accumulators, go to READ
- READ, row counter r runs 0..rows_lp-1:
  - each cycle: ram_v_o = 1, ram_addr_o = {wg, r}
  - if r > 0, also process ram_data_i (row r-1)
  - when r == rows_lp-1, go to LAST
- LAST: ram_v_o = 0; process the final row; go to DONE.
- Processing a row, for each LCE l in the row:
  - hit = any entry with tag == stored tag and coh_state != e_COH_I
  - way = lowest-indexed hitting entry; state = that entry's state
  - no hit: hits = 0, ways = 0, states = 0
- DONE:
  - sharers_v_o = 1; outputs held stable until sharers_yumi_i
  - on sharers_yumi_i, go to IDLE with lkup_ready_o = 1 the next cycle
  - back-to-back: a new lookup is not accepted in the yumi cycle
- Latency: lookup accepted at cycle 0 → sharers_v_o first high at cycle rows_lp+2.
- rows_lp == 1: READ lasts exactly one cycle, then LAST.
- lkup_v_i outside IDLE is ignored; the requester must hold it.
- sharers_yumi_i outside DONE is ignored.
- ram_data_i is ignored in every cycle not following a ram_v_o.

Optional Feature:
- Macro: BP_CCE_DIR_MULTIHIT_CHECK_EN
- Defined:
  - multihit_o is set when any LCE has more than one hitting entry in a processed row
  - multihit_o stays set until reset; lookup results are unaffected
- Undefined: multihit_o is tied to 0 and no checking logic is built.

Test Plan (num_lce_p=4, lce_assoc_p=2, lce_per_row_p=2, so rows_lp=2):
- Reset: hold reset_i=0 for 3 cycles → lkup_ready_o=0, sharers_v_o=0, ram_v_o=0. Release → lkup_ready_o=1.
- Single hit:
  - lookup wg=5, tag=0x123; RAM row1 LCE2 way1 = {0x123, E}
  - → ram_addr_o = {5,0} at cycle 1 and {5,1} at cycle 2
  - → sharers_v_o at cycle 4; hits=4'b0100, ways[2]=1, states[2]=E, all other fields 0
- Invalid match: tag matches in LCE0 with state I, and in LCE3 way0 with state S → hits=4'b1000.
- Hold and yumi:
  - keep sharers_yumi_i=0 for 5 cycles → outputs stable, lkup_ready_o=0
  - yumi → IDLE next cycle; second lookup ignored until then
- Mid-lookup reset: assert reset_i=0 in READ at r=1 → next cycle IDLE; no sharers_v_o ever for the aborted lookup.
- Multi-hit, macro defined: LCE1 both ways match in S → ways[1]=0, multihit_o=1 and stays 1 after yumi. Macro undefined: multihit_o=0.
